// File: rtl/data_mem_arb_pkg.sv
// Shared types for the data_mem arbiter.
// FSM states, default widths and the port index type.
package data_mem_arb_pkg;

  localparam int ARB_ADDR_W = 4;
  localparam int ARB_DATA_W = 4;

  typedef enum logic {
    ARB_IDLE,
    ARB_RD_WAIT
  } arb_state_e;

  typedef logic port_idx_t;

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick.
// The pointer register lives in the parent.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // last = index of the most recent winner; the other port wins a tie
  assign gnt[0] = req[0] & (~req[1] | last);
  assign gnt[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of data_mem.
// Writes issue every cycle; reads take a grant cycle plus a wait cycle.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_datain,
  input  logic [DATA_W-1:0] mem_dataout
);

  arb_state_e state, state_nxt;
  logic       last;
  port_idx_t  rd_port;
  port_idx_t  sel;
  logic [1:0] pick;
  logic [1:0] gnt;
  logic       any_gnt;
  logic       g_we;
  logic       rd_issue;

  rr_arb2 u_rr (
    .req  ({req1, req0}),
    .last (last),
    .gnt  (pick)
  );

  // Grants only in IDLE and never while reset is held
  always_comb begin
    gnt = 2'b00;
    if (!rst && state == ARB_IDLE) gnt = pick;
  end

  assign gnt0     = gnt[0];
  assign gnt1     = gnt[1];
  assign any_gnt  = |gnt;
  assign sel      = gnt[1];
  assign g_we     = sel ? we1 : we0;
  assign rd_issue = any_gnt & ~g_we;
  assign busy     = (state == ARB_RD_WAIT);

  always_comb begin
    state_nxt    = state;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    mem_addr     = '0;
    mem_datain   = '0;
    unique case (state)
      ARB_IDLE: begin
        if (any_gnt) begin
          mem_read_en  = ~g_we;
          mem_write_en = g_we;
          mem_addr     = sel ? addr1 : addr0;
          mem_datain   = sel ? wdata1 : wdata0;
          if (!g_we) state_nxt = ARB_RD_WAIT;
        end
      end
      ARB_RD_WAIT: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ARB_IDLE;
      last    <= 1'b1;
      rd_port <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      state   <= state_nxt;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      if (any_gnt) last <= sel;
      if (rd_issue) rd_port <= sel;
      // dataout is cleared at this edge; sample its pre-edge value
      if (state == ARB_RD_WAIT) begin
        if (rd_port) begin
          rvalid1 <= 1'b1;
          rdata1  <= mem_dataout;
        end else begin
          rvalid0 <= 1'b1;
          rdata0  <= mem_dataout;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural data_mem.
// Table of write vectors plus hand-written read/reset sequences.
module tb_data_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, we0, we1;
  logic [3:0] addr0, addr1, wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1, busy;
  logic [3:0] rdata0, rdata1;
  logic       mem_read_en, mem_write_en;
  logic [3:0] mem_addr, mem_datain, mem_dataout;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req0         (req0),
    .req1         (req1),
    .we0          (we0),
    .we1          (we1),
    .addr0        (addr0),
    .addr1        (addr1),
    .wdata0       (wdata0),
    .wdata1       (wdata1),
    .gnt0         (gnt0),
    .gnt1         (gnt1),
    .rvalid0      (rvalid0),
    .rvalid1      (rvalid1),
    .rdata0       (rdata0),
    .rdata1       (rdata1),
    .busy         (busy),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .mem_addr     (mem_addr),
    .mem_datain   (mem_datain),
    .mem_dataout  (mem_dataout)
  );

  // data_mem model, preloaded with mem[i] = i+1
  logic [3:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = 4'(i + 1);

  always @(posedge clk) begin
    if (mem_write_en) mem[mem_addr] <= mem_datain;
    mem_dataout <= mem_read_en ? mem[mem_addr] : 4'h0;
  end

  always @(negedge clk) begin
    if (mem_read_en && mem_write_en) begin
      n_bad++;
      $display("FAIL rw_overlap: read_en=1 write_en=1, required not both");
    end
  end

  typedef struct {
    logic       r0, w0;
    logic [3:0] a0, d0;
    logic       r1, w1;
    logic [3:0] a1, d1;
    logic [12:0] exp;
  } vec_t;

  function automatic logic [12:0] mk(logic g0, logic g1, logic re,
                                     logic we, logic [3:0] a,
                                     logic [3:0] d, logic b);
    return {g0, g1, re, we, a, d, b};
  endfunction

  function automatic logic [12:0] obs();
    return {gnt0, gnt1, mem_read_en, mem_write_en,
            mem_addr, mem_datain, busy};
  endfunction

  function automatic logic [9:0] rsp();
    return {rvalid0, rvalid1, rdata0, rdata1};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic w0,
                       input logic [3:0] a0, input logic [3:0] d0,
                       input logic r1, input logic w1,
                       input logic [3:0] a1, input logic [3:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  task automatic idle();
    drive(0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vt [10];

  initial begin
    vt[0] = '{0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, mk(0, 0, 0, 0, 4'h0, 4'h0, 0)};
    vt[1] = '{1, 1, 4'h3, 4'h1, 1, 1, 4'h4, 4'h2, mk(1, 0, 0, 1, 4'h3, 4'h1, 0)};
    vt[2] = '{1, 1, 4'h3, 4'h1, 1, 1, 4'h4, 4'h2, mk(0, 1, 0, 1, 4'h4, 4'h2, 0)};
    vt[3] = '{1, 1, 4'h3, 4'h1, 1, 1, 4'h4, 4'h2, mk(1, 0, 0, 1, 4'h3, 4'h1, 0)};
    vt[4] = '{1, 1, 4'h7, 4'hA, 0, 0, 4'h0, 4'h0, mk(1, 0, 0, 1, 4'h7, 4'hA, 0)};
    vt[5] = '{1, 1, 4'h8, 4'hB, 0, 0, 4'h0, 4'h0, mk(1, 0, 0, 1, 4'h8, 4'hB, 0)};
    vt[6] = '{1, 1, 4'h8, 4'hB, 1, 1, 4'h9, 4'hC, mk(0, 1, 0, 1, 4'h9, 4'hC, 0)};
    vt[7] = '{0, 0, 4'h0, 4'h0, 1, 1, 4'hF, 4'hF, mk(0, 1, 0, 1, 4'hF, 4'hF, 0)};
    vt[8] = '{1, 1, 4'h3, 4'h1, 1, 1, 4'h4, 4'h2, mk(1, 0, 0, 1, 4'h3, 4'h1, 0)};
    vt[9] = '{0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, mk(0, 0, 0, 0, 4'h0, 4'h0, 0)};

    // 1: reset and idle
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
    step();
    drive(1, 0, 4'h1, 4'h0, 0, 0, 4'h0, 4'h0);
    #1;
    chk("pre_rst_gnt", obs(), mk(1, 0, 1, 0, 4'h1, 4'h0, 0));
    #2;
    rst = 1'b1;
    #1;
    chk("rst_comb", obs(), 13'h0);
    chk("rst_rsp", rsp(), 10'h0);
    step();
    chk("rst_hold", {obs(), rsp()}, 23'h0);
    idle();
    rst = 1'b0;
    #1;
    chk("post_rst_idle", obs(), 13'h0);
    step();
    chk("post_rst_idle2", {obs(), rsp()}, 23'h0);

    // 4: table of write vectors, tie alternation from reset
    for (int i = 0; i < 10; i++) begin
      drive(vt[i].r0, vt[i].w0, vt[i].a0, vt[i].d0,
            vt[i].r1, vt[i].w1, vt[i].a1, vt[i].d1);
      #1;
      chk($sformatf("vec%0d", i), obs(), vt[i].exp);
      step();
    end

    // 2: port 0 write 9 to addr 5 then read it back
    drive(1, 1, 4'h5, 4'h9, 0, 0, 4'h0, 4'h0);
    #1;
    chk("p0_wr_gnt", obs(), mk(1, 0, 0, 1, 4'h5, 4'h9, 0));
    step();
    drive(1, 0, 4'h5, 4'h0, 0, 0, 4'h0, 4'h0);
    #1;
    chk("p0_rd_gnt", obs(), mk(1, 0, 1, 0, 4'h5, 4'h0, 0));
    step();
    idle();
    #1;
    chk("p0_rd_wait", {obs(), rsp()}, {mk(0, 0, 0, 0, 4'h0, 4'h0, 1), 10'h0});
    step();
    chk("p0_rvalid", {busy, rsp()}, {1'b0, 1'b1, 1'b0, 4'h9, 4'h0});
    step();
    chk("p0_rdata_hold", rsp(), {1'b0, 1'b0, 4'h9, 4'h0});

    // 3: port 1 reads preloaded addr 2
    drive(0, 0, 4'h0, 4'h0, 1, 0, 4'h2, 4'h0);
    #1;
    chk("p1_rd_gnt", obs(), mk(0, 1, 1, 0, 4'h2, 4'h0, 0));
    step();
    idle();
    #1;
    chk("p1_busy", {busy, rvalid1}, 2'b10);
    step();
    chk("p1_rvalid", {busy, rsp()}, {1'b0, 1'b0, 1'b1, 4'h9, 4'h3});
    step();
    chk("p1_rvalid_pulse", {busy, rvalid0, rvalid1}, 3'b000);

    // 5: port 1 write arrives while port 0 read is outstanding
    drive(1, 0, 4'h5, 4'h0, 0, 0, 4'h0, 4'h0);
    #1;
    chk("c_rd_gnt", obs(), mk(1, 0, 1, 0, 4'h5, 4'h0, 0));
    step();
    drive(0, 0, 4'h0, 4'h0, 1, 1, 4'h6, 4'h6);
    #1;
    chk("c_no_gnt_wait", obs(), mk(0, 0, 0, 0, 4'h0, 4'h0, 1));
    step();
    chk("c_gnt1_rvalid0", {obs(), rsp()},
        {mk(0, 1, 0, 1, 4'h6, 4'h6, 0), 1'b1, 1'b0, 4'h9, 4'h3});
    step();
    idle();

    // 6: reset during RD_WAIT drops the read and restores the pointer
    drive(1, 0, 4'h5, 4'h0, 0, 0, 4'h0, 4'h0);
    #1;
    chk("r_rd_gnt", obs(), mk(1, 0, 1, 0, 4'h5, 4'h0, 0));
    step();
    idle();
    #1;
    chk("r_busy", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("r_rst_clear", {busy, rsp()}, 11'h0);
    step();
    rst = 1'b0;
    #1;
    chk("r_no_rvalid0", {busy, rsp()}, 11'h0);
    step();
    chk("r_no_rvalid1", {busy, rsp()}, 11'h0);
    drive(1, 1, 4'hA, 4'h1, 1, 1, 4'hB, 4'h2);
    #1;
    chk("r_tie_p0", obs(), mk(1, 0, 0, 1, 4'hA, 4'h1, 0));
    step();
    idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
